poisson_array_sequencer: RTL
============================

Name: poisson_array_sequencer

Overview:
- Owns the neuron state memory for the Poisson neuron array.
- On every dT tick it sweeps all neurons, one per clock:
  - feeds each 13b state word to the Poisson update stage;
  - writes the updated word back one cycle later.
- Spiking neuron addresses are queued in an address-event (AER) FIFO with a valid/ready output.
- A host configuration port loads per-neuron activity between sweeps.

Parameters:
- N_NEURONS, 16, number of neurons in the array.
- ADDR_WIDTH, 4, neuron address width; N_NEURONS <= 2**ADDR_WIDTH.
- ACTIVITY_WIDTH, 9, activity field width, in 0.25 Hz units.
- REFRACTORY_WIDTH, 4, refractory counter field width.
- NEUR_WIDTH, ACTIVITY_WIDTH+REFRACTORY_WIDTH, state word width; layout is {activity, refractory}.
- FIFO_DEPTH, 8, spike FIFO entries; must be a power of 2.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous reset, active-high.
- tick  in  1  dT strobe, one cycle wide; starts a sweep.
- cfg_we  in  1  activity write strobe.
- cfg_addr  in  ADDR_WIDTH  neuron to configure.
- cfg_activity  in  ACTIVITY_WIDTH  activity value to load.
- poisson_en  out  1  update enable to the Poisson stage.
- poisson_in  out  NEUR_WIDTH  state word to the Poisson stage.
- poisson_out  in  NEUR_WIDTH  updated word from the Poisson stage; valid 1 cycle after poisson_en.
- spike  in  1  spike flag from the Poisson stage; same timing as poisson_out.
- aer_valid  out  1  spike FIFO not empty.
- aer_addr  out  ADDR_WIDTH  neuron address at the FIFO head.
- aer_ready  in  1  consumer accepts the head entry.
- busy  out  1  sweep in progress.
- overrun  out  1  sticky: tick arrived while busy.
- overflow  out  1  sticky: a spike was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - all state words = 0; FSM = IDLE; FIFO empty;
  - aer_valid = 0, busy = 0, overrun = 0, overflow = 0, poisson_en = 0, poisson_in = 0.
- Reset mid-sweep aborts the sweep and clears memory, FIFO and flags in the same cycle.
- FSM states: IDLE, SWEEP, DRAIN.
  - IDLE -> SWEEP on tick; rd_addr is set to 0.
  - SWEEP: poisson_en = 1, poisson_in = mem[rd_addr]; rd_addr increments each cycle.
  - SWEEP -> DRAIN after the cycle with rd_addr = N_NEURONS-1.
  - DRAIN: poisson_en = 0; captures the last result; DRAIN -> IDLE after 1 cycle.
- busy = (state != IDLE).
- Timing: tick at cycle t gives poisson_en high on cycles t+1 .. t+N_NEURONS, and busy low again at cycle t+N_NEURONS+2.
- Writeback pipeline:
  - wb_addr is rd_addr delayed 1 cycle; wb_valid is poisson_en delayed 1 cycle.
  - When wb_valid: mem[wb_addr] <= poisson_out.
  - When wb_valid & spike: push wb_addr into the FIFO.
  - spike is ignored when wb_valid = 0.
- Outside SWEEP, poisson_in is held at 0.
- tick while busy is ignored and sets overrun; overrun clears only on reset.
- Configuration:
  - cfg_we in IDLE writes mem[cfg_addr] <= {cfg_activity, 0}; the refractory field is cleared.
  - cfg_we while busy is ignored.
  - cfg_addr >= N_NEURONS is ignored.
  - cfg_we and tick in the same IDLE cycle: the write commits first, and the sweep uses the new value.
- FIFO:
  - aer_valid = !empty; aer_addr = head entry.
  - Pop when aer_valid & aer_ready.
  - Push is accepted if not full, or if full and a pop happens in the same cycle.
  - Otherwise the spike is dropped, overflow is set, and writeback still occurs.
  - Push and pop in the same cycle: count is unchanged; order is preserved.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Spikes within one sweep enter the FIFO in ascending address order.
- FIFO data persists across sweeps; the consumer may drain it during later sweeps.

Test Plan:
- Reset, then tick with no cfg writes; the bench Poisson stub echoes poisson_in and drives spike = 0 -> poisson_en high for exactly 16 cycles; poisson_in = 0 each cycle; busy high 17 cycles; aer_valid stays 0.
- cfg_we addr 3 activity 9'd100, then tick; stub returns poisson_in with refractory = 4 and spike = 1 only for addr 3 -> aer_addr = 3 with aer_valid high 2 cycles after its poisson_en cycle; next sweep presents poisson_in for addr 3 = {100, 4}.
- Stub spikes every neuron, aer_ready = 0 -> FIFO holds 0..7; overflow sets on addr 8; all 16 words are still written back; then aer_ready = 1 pops 0..7 in order.
- tick pulsed again 5 cycles into a sweep -> ignored, overrun = 1, sweep length unchanged; cfg_we during the sweep -> memory unchanged.
- FIFO full with aer_ready = 1 while stub spike = 1 -> simultaneous push and pop, no overflow, count stays 8.
- Assert reset mid-sweep at rd_addr = 6 -> next cycle busy = 0, aer_valid = 0, flags = 0, and the next sweep presents all-zero words.

Source files
------------

// File: rtl/poisson_array_sequencer.sv
// Neuron state memory and sweep sequencer for the Poisson neuron array.
// Each dT tick streams every state word through the update stage, writes it back and queues spikes as AER events.
module poisson_array_sequencer #(
    parameter int N_NEURONS        = 16,
    parameter int ADDR_WIDTH       = 4,
    parameter int ACTIVITY_WIDTH   = 9,
    parameter int REFRACTORY_WIDTH = 4,
    parameter int NEUR_WIDTH       = ACTIVITY_WIDTH + REFRACTORY_WIDTH,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      cfg_we,
    input  logic [ADDR_WIDTH-1:0]     cfg_addr,
    input  logic [ACTIVITY_WIDTH-1:0] cfg_activity,
    output logic                      poisson_en,
    output logic [NEUR_WIDTH-1:0]     poisson_in,
    input  logic [NEUR_WIDTH-1:0]     poisson_out,
    input  logic                      spike,
    output logic                      aer_valid,
    output logic [ADDR_WIDTH-1:0]     aer_addr,
    input  logic                      aer_ready,
    output logic                      busy,
    output logic                      overrun,
    output logic                      overflow
);

    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_NEURONS - 1);
    localparam logic [FW:0] FIFO_FULL = (FW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t state, state_nxt;

    logic [NEUR_WIDTH-1:0] mem [N_NEURONS];
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic                  wb_valid;
    logic                  cfg_hit;

    logic [ADDR_WIDTH-1:0] fifo [FIFO_DEPTH];
    logic [FW-1:0]         rd_ptr;
    logic [FW-1:0]         wr_ptr;
    logic [FW:0]           count;
    logic                  full;
    logic                  pop;
    logic                  push_req;
    logic                  push;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = SWEEP;
            SWEEP:   if (rd_addr == LAST_ADDR) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign poisson_en = (state == SWEEP);
    assign poisson_in = poisson_en ? mem[rd_addr] : '0;

    // Host writes only land between sweeps; a same-cycle tick sees the new word one cycle later.
    assign cfg_hit = cfg_we && (state == IDLE) && (32'(cfg_addr) < N_NEURONS);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) mem[i] <= '0;
        end else begin
            if (wb_valid) mem[wb_addr] <= poisson_out;
            if (cfg_hit)  mem[cfg_addr] <= {cfg_activity, {REFRACTORY_WIDTH{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr  <= '0;
            wb_addr  <= '0;
            wb_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            wb_valid <= poisson_en;
            wb_addr  <= rd_addr;
            if (state == IDLE && tick) rd_addr <= '0;
            else if (state == SWEEP)   rd_addr <= rd_addr + 1'b1;
            if (tick && busy) overrun <= 1'b1;
        end
    end

    // A full FIFO still accepts a spike when the head leaves in the same cycle.
    assign aer_valid = (count != '0);
    assign aer_addr  = fifo[rd_ptr];
    assign full      = (count == FIFO_FULL);
    assign pop       = aer_valid && aer_ready;
    assign push_req  = wb_valid && spike;
    assign push      = push_req && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= wb_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (push_req && !push) overflow <= 1'b1;
        end
    end

endmodule
